conv_datapath_sequencer: RTL and testbench

//  Instruction-level controller for the configurable CONV/DWCONV/PWCONV datapath. Accepts one layer-tile

---
 rtl/conv_datapath_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_conv_datapath_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_datapath_sequencer.sv
// Sequences one CONV layer-tile instruction: config pulse, per row/tile shift + Tm weight reads + drain.
// Defining SEQ_PERF_CNT_EN adds the perf_cycles busy-cycle counter port.
module conv_datapath_sequencer #(
  parameter int Tm         = 16,
  parameter int PIPE_LAT   = 8,
  parameter int ROW_WIDTH  = 8,
  parameter int TILE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_valid,
  output logic                  inst_ready,
  input  logic [7:0]            inst_com_type,
  input  logic [3:0]            inst_kernel_size,
  input  logic [ROW_WIDTH-1:0]  inst_rows,
  input  logic [TILE_WIDTH-1:0] inst_tiles,
  input  logic [15:0]           inst_weight_base,
  output logic                  config_enable,
  output logic                  config_clear,
  output logic [7:0]            com_type,
  output logic [3:0]            kernel_size,
  output logic                  virtical_reg_shift,
  output logic                  virreg_input_sel,
  input  logic                  shift_done,
  output logic                  weight_read_en,
  output logic [15:0]           weight_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  localparam int OC_W = (Tm > 1) ? $clog2(Tm) : 1;
  localparam int DR_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [7:0]      COM_CONV  = 8'h01;
  localparam logic [15:0]     TM_STRIDE = 16'(Tm);
  localparam logic [OC_W-1:0] OC_LAST   = OC_W'(Tm - 1);
  localparam logic [DR_W-1:0] DR_LAST   = DR_W'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONFIG,
    S_SHIFT,
    S_COMPUTE,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t                  state_reg, state_next;
  logic [7:0]              com_type_reg;
  logic [3:0]              kernel_size_reg;
  logic [ROW_WIDTH-1:0]    rows_reg;
  logic [TILE_WIDTH-1:0]   tiles_reg;
  logic [15:0]             base_reg;
  logic [ROW_WIDTH-1:0]    row_reg, row_next;
  logic [TILE_WIDTH-1:0]   tile_reg, tile_next;
  logic [OC_W-1:0]         oc_reg, oc_next;
  logic [DR_W-1:0]         drain_reg, drain_next;
  logic                    sel_reg, sel_next;
  logic                    accept;

  assign accept = inst_valid && (state_reg == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      com_type_reg    <= '0;
      kernel_size_reg <= '0;
      rows_reg        <= '0;
      tiles_reg       <= '0;
      base_reg        <= '0;
      row_reg         <= '0;
      tile_reg        <= '0;
      oc_reg          <= '0;
      drain_reg       <= '0;
      sel_reg         <= 1'b0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      tile_reg  <= tile_next;
      oc_reg    <= oc_next;
      drain_reg <= drain_next;
      sel_reg   <= sel_next;
      if (accept) begin
        com_type_reg    <= inst_com_type;
        kernel_size_reg <= inst_kernel_size;
        rows_reg        <= inst_rows;
        tiles_reg       <= inst_tiles;
        base_reg        <= inst_weight_base;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    tile_next  = tile_reg;
    oc_next    = oc_reg;
    drain_next = drain_reg;
    sel_next   = sel_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = S_CONFIG;
          row_next   = '0;
          tile_next  = '0;
          oc_next    = '0;
          drain_next = '0;
          sel_next   = 1'b0;
        end
      end
      S_CONFIG: begin
        // Unsupported opcodes and empty workloads skip straight to the completion pulse
        if (com_type_reg != COM_CONV || rows_reg == '0 || tiles_reg == '0)
          state_next = S_FINISH;
        else
          state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (shift_done) begin
          state_next = S_COMPUTE;
          oc_next    = '0;
        end
      end
      S_COMPUTE: begin
        if (oc_reg == OC_LAST) begin
          state_next = S_DRAIN;
          drain_next = '0;
        end else begin
          oc_next = oc_reg + OC_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_reg == DR_LAST) begin
          drain_next = '0;
          if (tile_reg == tiles_reg - TILE_WIDTH'(1)) begin
            tile_next = '0;
            row_next  = row_reg + ROW_WIDTH'(1);
            sel_next  = ~sel_reg;
            state_next = (row_reg == rows_reg - ROW_WIDTH'(1)) ? S_FINISH : S_SHIFT;
          end else begin
            tile_next  = tile_reg + TILE_WIDTH'(1);
            state_next = S_SHIFT;
          end
        end else begin
          drain_next = drain_reg + DR_W'(1);
        end
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  assign inst_ready         = (state_reg == S_IDLE);
  assign busy               = (state_reg != S_IDLE);
  assign config_enable      = (state_reg == S_CONFIG);
  assign config_clear       = (state_reg == S_FINISH);
  assign done               = (state_reg == S_FINISH);
  assign err                = (state_reg == S_FINISH) && (com_type_reg != COM_CONV);
  assign com_type           = com_type_reg;
  assign kernel_size        = kernel_size_reg;
  assign virtical_reg_shift = (state_reg == S_SHIFT);
  assign virreg_input_sel   = sel_reg;
  assign weight_read_en     = (state_reg == S_COMPUTE);
  // Address is forced to zero outside the read burst so idle outputs stay quiet
  assign weight_addr        = (state_reg == S_COMPUTE)
                              ? base_reg + 16'(tile_reg) * TM_STRIDE + 16'(oc_reg)
                              : 16'h0000;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_reg;

  always_ff @(posedge clk) begin
    if (rst)
      perf_reg <= '0;
    else if (accept)
      perf_reg <= '0;
    else if (state_reg != S_IDLE && perf_reg != 32'hFFFF_FFFF)
      perf_reg <= perf_reg + 32'd1;
  end

  assign perf_cycles = perf_reg;
`endif

endmodule

// File: tb/tb_conv_datapath_sequencer.sv
// Self-checking bench for conv_datapath_sequencer: directed table, reset abort, randomized instructions.
module tb_conv_datapath_sequencer;
  localparam int TM = 16;
  localparam int PL = 8;

  logic        clk;
  logic        rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [7:0]  inst_com_type;
  logic [3:0]  inst_kernel_size;
  logic [7:0]  inst_rows;
  logic [7:0]  inst_tiles;
  logic [15:0] inst_weight_base;
  logic        config_enable;
  logic        config_clear;
  logic [7:0]  com_type;
  logic [3:0]  kernel_size;
  logic        virtical_reg_shift;
  logic        virreg_input_sel;
  logic        shift_done;
  logic        weight_read_en;
  logic [15:0] weight_addr;
  logic        busy;
  logic        done;
  logic        err;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  conv_datapath_sequencer #(.Tm(TM), .PIPE_LAT(PL), .ROW_WIDTH(8), .TILE_WIDTH(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .inst_valid        (inst_valid),
    .inst_ready        (inst_ready),
    .inst_com_type     (inst_com_type),
    .inst_kernel_size  (inst_kernel_size),
    .inst_rows         (inst_rows),
    .inst_tiles        (inst_tiles),
    .inst_weight_base  (inst_weight_base),
    .config_enable     (config_enable),
    .config_clear      (config_clear),
    .com_type          (com_type),
    .kernel_size       (kernel_size),
    .virtical_reg_shift(virtical_reg_shift),
    .virreg_input_sel  (virreg_input_sel),
    .shift_done        (shift_done),
    .weight_read_en    (weight_read_en),
    .weight_addr       (weight_addr),
    .busy              (busy),
    .done              (done),
    .err               (err)
`ifdef SEQ_PERF_CNT_EN
    ,
    .perf_cycles       (perf_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  com;
    logic [3:0]  ks;
    logic [7:0]  rows;
    logic [7:0]  tiles;
    logic [15:0] base;
    int          dly;
    bit          vnoise;
    bit          sdnoise;
    bit          exp_err;
    int          exp_reads;
    int          exp_shifts;
    int          exp_busy;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int shift_delay = 0;
  bit sd_noise = 1'b0;
  int sh_k = 0;
  vec_t tbl[8];

  // shift_done responder: asserts after shift_delay cycles of request, random noise otherwise
  always @(negedge clk) begin
    if (virtical_reg_shift === 1'b1) begin
      sh_k = sh_k + 1;
      shift_done = (sh_k > shift_delay);
    end else begin
      sh_k = 0;
      shift_done = sd_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit   run;
    r = v;
    run = (v.com == 8'h01) && (v.rows != 0) && (v.tiles != 0);
    r.exp_err    = (v.com != 8'h01);
    r.exp_reads  = run ? int'(v.rows) * int'(v.tiles) * TM : 0;
    r.exp_shifts = run ? int'(v.rows) * int'(v.tiles) : 0;
    r.exp_busy   = 2 + (run ? int'(v.rows) * int'(v.tiles) * (v.dly + 1 + TM + PL) : 0);
    return r;
  endfunction

  task automatic run_inst(input vec_t v, input string tag);
    logic [15:0] exp_addr[$];
    bit          exp_sel[$];
    logic [15:0] got_addr[$];
    bit          got_sel[$];
    int cyc, busy_n, shifts_n, cfg_n, cfg_cyc, done_cyc, last_rd, ready_bad, stray, type_bad, n;
    bit got_err, got_clr, prev_sh, fin;
    cyc = 0; busy_n = 0; shifts_n = 0; cfg_n = 0; cfg_cyc = 0; done_cyc = 0; last_rd = 0;
    ready_bad = 0; stray = 0; type_bad = 0; got_err = 0; got_clr = 0; prev_sh = 0; fin = 0;

    if (v.com == 8'h01)
      for (int r = 0; r < int'(v.rows); r++)
        for (int t = 0; t < int'(v.tiles); t++)
          for (int oc = 0; oc < TM; oc++) begin
            exp_addr.push_back(v.base + 16'(t * TM + oc));
            exp_sel.push_back(bit'(r % 2));
          end

    shift_delay = v.dly;
    sd_noise    = v.sdnoise;
    @(negedge clk);
    chk({tag, "/ready_idle"}, inst_ready, 1);
    inst_com_type    = v.com;
    inst_kernel_size = v.ks;
    inst_rows        = v.rows;
    inst_tiles       = v.tiles;
    inst_weight_base = v.base;
    inst_valid       = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    cyc = 1;
    while (!fin && cyc < 5000) begin
      busy_n += int'(busy);
      if (inst_ready == busy) ready_bad++;
      if (config_enable) begin
        cfg_n++;
        cfg_cyc = cyc;
        if (com_type !== v.com || kernel_size !== v.ks) type_bad++;
      end
      if (weight_read_en) begin
        got_addr.push_back(weight_addr);
        got_sel.push_back(virreg_input_sel);
        last_rd = cyc;
      end
      if (virtical_reg_shift && !prev_sh) shifts_n++;
      prev_sh = virtical_reg_shift;
      if ((err || config_clear) && !done) stray++;
      if (done) begin
        fin = 1;
        done_cyc = cyc;
        got_err = err;
        got_clr = config_clear;
      end
      if (!fin && v.vnoise) begin
        inst_valid       = 1'($urandom_range(0, 1));
        inst_com_type    = 8'($urandom);
        inst_kernel_size = 4'($urandom);
        inst_rows        = 8'($urandom);
        inst_tiles       = 8'($urandom);
        inst_weight_base = 16'($urandom);
      end else begin
        inst_valid = 1'b0;
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    inst_valid = 1'b0;

    chk({tag, "/done_seen"}, fin, 1);
    chk({tag, "/err"}, got_err, v.exp_err);
    chk({tag, "/clear_with_done"}, got_clr, 1);
    chk({tag, "/stray_err_clear"}, stray, 0);
    chk({tag, "/cfg_count"}, cfg_n, 1);
    chk({tag, "/cfg_cycle"}, cfg_cyc, 1);
    chk({tag, "/cfg_fields"}, type_bad, 0);
    chk({tag, "/ready_vs_busy"}, ready_bad, 0);
    chk({tag, "/reads"}, got_addr.size(), v.exp_reads);
    chk({tag, "/model_reads"}, got_addr.size(), exp_addr.size());
    chk({tag, "/shifts"}, shifts_n, v.exp_shifts);
    chk({tag, "/busy_cycles"}, busy_n, v.exp_busy);
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s/addr%0d", tag, i), got_addr[i], exp_addr[i]);
      chk($sformatf("%s/sel%0d", tag, i), got_sel[i], exp_sel[i]);
    end
    if (v.exp_reads > 0)
      chk({tag, "/drain_latency"}, done_cyc - last_rd, PL + 1);

    @(negedge clk);
    chk({tag, "/idle_after"}, {busy, inst_ready, done, config_clear, weight_read_en}, 5'b01000);
`ifdef SEQ_PERF_CNT_EN
    chk({tag, "/perf"}, perf_cycles, v.exp_busy);
`endif
    $display("txn %s com=%02h rows=%0d tiles=%0d base=%04h dly=%0d reads=%0d shifts=%0d busy=%0d err=%0d",
             tag, v.com, v.rows, v.tiles, v.base, v.dly, got_addr.size(), shifts_n, busy_n, got_err);
  endtask

  initial begin
    vec_t v;
    bit   seen;
    //        com    ks    rows   tiles  base      dly vn sdn err reads shifts busy
    tbl[0] = '{8'h01, 4'h3, 8'd1, 8'd1, 16'h0100, 3, 0, 0, 0, 16, 1, 30};
    tbl[1] = '{8'h01, 4'h3, 8'd2, 8'd2, 16'h0000, 1, 0, 1, 0, 64, 4, 106};
    tbl[2] = '{8'h02, 4'h5, 8'd1, 8'd1, 16'h0000, 0, 0, 0, 1, 0, 0, 2};
    tbl[3] = '{8'h01, 4'h1, 8'd0, 8'd3, 16'h0000, 0, 1, 0, 0, 0, 0, 2};
    tbl[4] = '{8'h01, 4'h1, 8'd1, 8'd0, 16'h0040, 0, 0, 1, 0, 0, 0, 2};
    tbl[5] = '{8'h04, 4'h2, 8'd0, 8'd0, 16'h0000, 0, 0, 0, 1, 0, 0, 2};
    tbl[6] = '{8'h01, 4'h3, 8'd1, 8'd1, 16'hFFF8, 0, 0, 0, 0, 16, 1, 27};
    tbl[7] = '{8'h01, 4'h7, 8'd3, 8'd1, 16'h1234, 2, 1, 1, 0, 48, 3, 83};

    rst = 1'b1;
    inst_valid = 1'b0;
    inst_com_type = '0;
    inst_kernel_size = '0;
    inst_rows = '0;
    inst_tiles = '0;
    inst_weight_base = '0;
    repeat (3) @(negedge clk);
    chk("reset/ready", inst_ready, 1);
    chk("reset/ctrl", {busy, config_enable, config_clear, virtical_reg_shift, virreg_input_sel,
                       weight_read_en, done, err}, 8'h00);
    chk("reset/data", {com_type, kernel_size, weight_addr}, 28'h0);
`ifdef SEQ_PERF_CNT_EN
    chk("reset/perf", perf_cycles, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_inst(tbl[i], $sformatf("tbl%0d", i));

    // Abort mid-burst via reset, then confirm a clean instruction afterwards
    @(negedge clk);
    shift_delay = 1;
    sd_noise = 1'b0;
    inst_com_type = 8'h01; inst_kernel_size = 4'h7; inst_rows = 8'd2; inst_tiles = 8'd2;
    inst_weight_base = 16'h4000;
    inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (weight_read_en) seen = 1;
      else @(negedge clk);
    end
    chk("rst_mid/reached_compute", seen, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid/ready", inst_ready, 1);
    chk("rst_mid/ctrl", {busy, config_enable, config_clear, virtical_reg_shift, virreg_input_sel,
                         weight_read_en, done, err}, 8'h00);
    chk("rst_mid/data", {com_type, kernel_size, weight_addr}, 28'h0);
    rst = 1'b0;
    run_inst(tbl[0], "after_rst");

    for (int i = 0; i < 24; i++) begin
      int pick;
      pick = int'($urandom_range(0, 9));
      v.com = (pick < 7) ? 8'h01 : (pick == 7) ? 8'h02 : (pick == 8) ? 8'h04 : 8'($urandom);
      v.ks = 4'($urandom);
      v.rows = 8'($urandom_range(0, 3));
      v.tiles = 8'($urandom_range(0, 3));
      v.base = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'hFFFF - 16'($urandom_range(0, 40));
      v.dly = int'($urandom_range(0, 4));
      v.vnoise = 1'($urandom_range(0, 1));
      v.sdnoise = 1'($urandom_range(0, 1));
      v = model(v);
      run_inst(v, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
